// File: rtl/gem_sort_pkg.sv
// Shared constants for the GEM-CLCT minimum-finder tree.
// Candidate layout is {vld, pri, xky, idx}, most-significant field first.
package gem_sort_pkg;

    localparam int unsigned PRI_W_DEF     = 10;
    localparam int unsigned XKY_W_DEF     = 10;
    localparam int unsigned IDX_W_MAX     = 6;
    localparam int unsigned NOMATCH_CNT_W = 16;

    // Equal priorities resolve to the lower window index
    localparam bit TIE_LOW_IDX = 1'b1;

    typedef struct packed {
        logic                 vld;
        logic [PRI_W_DEF-1:0] pri;
        logic [XKY_W_DEF-1:0] xky;
        logic [IDX_W_MAX-1:0] idx;
    } cand_t;

endpackage

// File: rtl/gem_sort_node.sv
// Combinational compare-select of two candidates; with GEM_SORT_SECOND_EN
// defined it also produces the runner-up of the merged pair of subtrees.
module gem_sort_node
    import gem_sort_pkg::*;
#(
    parameter  int unsigned PRI_W = PRI_W_DEF,
    parameter  int unsigned XKY_W = XKY_W_DEF,
    parameter  int unsigned IDX_W = 4,
    localparam int unsigned CW    = 1 + PRI_W + XKY_W + IDX_W
) (
    input  logic [CW-1:0] a_best,
    input  logic [CW-1:0] b_best,
`ifdef GEM_SORT_SECOND_EN
    input  logic [CW-1:0] a_2nd,
    input  logic [CW-1:0] b_2nd,
    output logic [CW-1:0] second_c,
`endif
    output logic [CW-1:0] best_c
);

    function automatic logic beats(
        input logic             x_vld,
        input logic [PRI_W-1:0] x_pri,
        input logic [IDX_W-1:0] x_idx,
        input logic             y_vld,
        input logic [PRI_W-1:0] y_pri,
        input logic [IDX_W-1:0] y_idx
    );
        logic idx_win;
        idx_win = TIE_LOW_IDX ? (x_idx < y_idx) : (x_idx > y_idx);
        if (x_vld && y_vld) begin
            return (x_pri < y_pri) || ((x_pri == y_pri) && idx_win);
        end
        return x_vld;
    endfunction

    // Two invalid candidates collapse to an all-zero invalid candidate
    function automatic logic [CW-1:0] sel(input logic [CW-1:0] x, input logic [CW-1:0] y);
        if (!x[CW-1] && !y[CW-1]) begin
            return '0;
        end
        return beats(x[CW-1], x[CW-2 -: PRI_W], x[IDX_W-1:0],
                     y[CW-1], y[CW-2 -: PRI_W], y[IDX_W-1:0]) ? x : y;
    endfunction

`ifdef GEM_SORT_SECOND_EN
    logic a_wins_c;

    always_comb begin
        a_wins_c = 1'b0;
        best_c   = '0;
        second_c = '0;
        a_wins_c = beats(a_best[CW-1], a_best[CW-2 -: PRI_W], a_best[IDX_W-1:0],
                         b_best[CW-1], b_best[CW-2 -: PRI_W], b_best[IDX_W-1:0]);
        best_c   = sel(a_best, b_best);
        // Runner-up is the better of the loser's best and the winner's runner-up
        second_c = a_wins_c ? sel(b_best, a_2nd) : sel(a_best, b_2nd);
    end
`else
    always_comb begin
        best_c = '0;
        best_c = sel(a_best, b_best);
    end
`endif

endmodule

// File: rtl/gem_clct_tree_sort.sv
// Pipelined binary-tree minimum finder over N_WIN GEM-CLCT windows, one level per
// clock. Runner-up outputs exist only when GEM_SORT_SECOND_EN is defined.
module gem_clct_tree_sort
    import gem_sort_pkg::*;
#(
    parameter  int unsigned N_WIN = 16,
    parameter  int unsigned PRI_W = PRI_W_DEF,
    parameter  int unsigned XKY_W = XKY_W_DEF,
    localparam int unsigned IDX_W = $clog2(N_WIN)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     valid_in,
    input  logic [N_WIN-1:0]         win_vld,
    input  logic [N_WIN*PRI_W-1:0]   win_pri,
    input  logic [N_WIN*XKY_W-1:0]   gem_xky,
    input  logic                     cnt_clr,
    output logic                     valid_out,
    output logic                     best_vld,
    output logic [PRI_W-1:0]         pri_best,
    output logic [XKY_W-1:0]         xky_best,
    output logic [IDX_W-1:0]         win_best,
`ifdef GEM_SORT_SECOND_EN
    output logic [PRI_W-1:0]         pri_2nd,
    output logic [XKY_W-1:0]         xky_2nd,
    output logic [IDX_W-1:0]         win_2nd,
    output logic                     vld_2nd,
`endif
    output logic [NOMATCH_CNT_W-1:0] nomatch_cnt
);

    localparam int unsigned L      = IDX_W;
    localparam int unsigned CW     = 1 + PRI_W + XKY_W + IDX_W;
    localparam int unsigned N_NODE = N_WIN - 1;

    // Nodes are stored level by level: level k starts at N_WIN - (N_WIN >> (k-1))
    logic [CW-1:0] leaf   [N_WIN];
    logic [CW-1:0] node_c [N_NODE];
    logic [CW-1:0] node_q [N_NODE];
`ifdef GEM_SORT_SECOND_EN
    logic [CW-1:0] node2_c [N_NODE];
    logic [CW-1:0] node2_q [N_NODE];
`endif
    logic [L-1:0]  vld_sr;

    for (genvar i = 0; i < N_WIN; i++) begin : g_leaf
        assign leaf[i] = {win_vld[i], win_pri[i*PRI_W +: PRI_W],
                          gem_xky[i*XKY_W +: XKY_W], IDX_W'(i)};
    end

    for (genvar k = 1; k <= L; k++) begin : g_lvl
        localparam int unsigned NN   = N_WIN >> k;
        localparam int unsigned BASE = N_WIN - (N_WIN >> (k - 1));
        for (genvar j = 0; j < NN; j++) begin : g_node
            logic [CW-1:0] a_best;
            logic [CW-1:0] b_best;
`ifdef GEM_SORT_SECOND_EN
            logic [CW-1:0] a_2nd;
            logic [CW-1:0] b_2nd;
`endif
            if (k == 1) begin : g_from_leaf
                assign a_best = leaf[2*j];
                assign b_best = leaf[2*j+1];
`ifdef GEM_SORT_SECOND_EN
                assign a_2nd  = '0;
                assign b_2nd  = '0;
`endif
            end else begin : g_from_node
                localparam int unsigned PREV = N_WIN - (N_WIN >> (k - 2));
                assign a_best = node_q[PREV+2*j];
                assign b_best = node_q[PREV+2*j+1];
`ifdef GEM_SORT_SECOND_EN
                assign a_2nd  = node2_q[PREV+2*j];
                assign b_2nd  = node2_q[PREV+2*j+1];
`endif
            end

            gem_sort_node #(
                .PRI_W (PRI_W),
                .XKY_W (XKY_W),
                .IDX_W (IDX_W)
            ) u_node (
                .a_best   (a_best),
                .b_best   (b_best),
`ifdef GEM_SORT_SECOND_EN
                .a_2nd    (a_2nd),
                .b_2nd    (b_2nd),
                .second_c (node2_c[BASE+j]),
`endif
                .best_c   (node_c[BASE+j])
            );
        end
    end

    // Data registers load every cycle; only the valid shift register qualifies them
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_NODE; i++) begin
                node_q[i] <= '0;
`ifdef GEM_SORT_SECOND_EN
                node2_q[i] <= '0;
`endif
            end
            vld_sr <= '0;
        end else begin
            for (int i = 0; i < N_NODE; i++) begin
                node_q[i] <= node_c[i];
`ifdef GEM_SORT_SECOND_EN
                node2_q[i] <= node2_c[i];
`endif
            end
            vld_sr[0] <= valid_in;
            for (int i = 1; i < L; i++) begin
                vld_sr[i] <= vld_sr[i-1];
            end
        end
    end

    assign valid_out = vld_sr[L-1];
    assign best_vld  = node_q[N_NODE-1][CW-1];
    assign pri_best  = node_q[N_NODE-1][CW-2 -: PRI_W];
    assign xky_best  = node_q[N_NODE-1][IDX_W +: XKY_W];
    assign win_best  = node_q[N_NODE-1][IDX_W-1:0];
`ifdef GEM_SORT_SECOND_EN
    assign vld_2nd   = node2_q[N_NODE-1][CW-1];
    assign pri_2nd   = node2_q[N_NODE-1][CW-2 -: PRI_W];
    assign xky_2nd   = node2_q[N_NODE-1][IDX_W +: XKY_W];
    assign win_2nd   = node2_q[N_NODE-1][IDX_W-1:0];
`endif

    // Counts presented results with no valid window; clear wins over increment
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            nomatch_cnt <= '0;
        end else if (cnt_clr) begin
            nomatch_cnt <= '0;
        end else if (valid_out && !best_vld && (nomatch_cnt != '1)) begin
            nomatch_cnt <= nomatch_cnt + NOMATCH_CNT_W'(1);
        end
    end

endmodule

// File: doc/gem_clct_tree_sort.md
# gem_clct_tree_sort

Pipelined, parametrised minimum-finder for GEM–CLCT matching: each cycle it takes N_WIN candidate windows, each with a bending-angle priority, a GEM key and a match-valid flag. It returns the valid window with the smallest priority, together with its GEM key and window index. It sits between the GEM–CLCT window matcher and the ALCT–CLCT–GEM correlation logic. Because it is fully pipelined, it accepts a new event every clock.

## Interface
- N_WIN, 16: number of candidate windows; power of 2, range 2..64.
- PRI_W, 10: width of the priority (bending angle) field.
- XKY_W, 10: width of the GEM key field.
- IDX_W, clog2(N_WIN): width of the window index (derived; do not override).
- clock  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- valid_in  in  1  candidate bus holds a new event.
- win_vld  in  N_WIN  per-window match-valid; bit i qualifies window i.
- win_pri  in  N_WIN*PRI_W  priorities, flattened; window i at [i*PRI_W +: PRI_W].
- gem_xky  in  N_WIN*XKY_W  GEM keys, flattened; window i at [i*XKY_W +: XKY_W].
- cnt_clr  in  1  synchronous clear of the no-match counter.
- valid_out  out  1  result for one event is present.
- best_vld  out  1  at least one window of that event was valid.
- pri_best  out  PRI_W  priority of the selected window.
- xky_best  out  XKY_W  GEM key of the selected window.
- win_best  out  IDX_W  index of the selected window.
- nomatch_cnt  out  16  saturating count of events with no valid window.
- pri_2nd, xky_2nd, win_2nd, vld_2nd  out  PRI_W/XKY_W/IDX_W/1  runner-up result; present only when GEM_SORT_SECOND_EN is defined.

## Operation
- The tree is binary with L = IDX_W levels. Level k reduces pairs of candidates from level k-1.
- Node rule:
  - A valid candidate beats an invalid one.
  - Between two valid candidates, the one with the strictly smaller priority wins.
  - On equal priorities, the lower window index wins.
  - If both candidates are invalid, the node outputs an invalid candidate with all fields 0.
- Each node output carries {vld, pri, xky, idx}. The index is built level by level, with the winner's branch bit as the MSB-side extension. The final index therefore equals the original window number.
- If all windows are invalid: best_vld=0, pri_best=0, xky_best=0, win_best=0.
- With win_vld all-ones and N_WIN=8, the result is identical to the legacy 8-window sorter.
- Priorities are compared as unsigned values. No arithmetic is performed; all widths are carried through unchanged.
- nomatch_cnt increments when valid_out=1 and best_vld=0, and saturates at 16'hFFFF.
- cnt_clr has priority over a simultaneous increment; the counter becomes 0.

## Timing
- Every tree level is registered. Latency is exactly L cycles from the valid_in edge to valid_out (L=4 for N_WIN=16).
- Throughput is one event per clock. There is no stall and no back-pressure.
- valid_in propagates through an L-deep valid shift register. Data registers load every cycle, whether or not the event is valid.
- Output fields are meaningful only while valid_out=1. When valid_out=0 the result holds its last value; it is not required to be zero.
- Reset values: all pipeline registers, valid_out, best_vld, pri_best, xky_best, win_best and nomatch_cnt are 0; runner-up outputs are also 0.
- Reset asserted mid-pipeline discards all in-flight events; no valid_out is produced for them.
- An event entering on the cycle reset_n deasserts is accepted normally.

## Configuration
- GEM_SORT_SECOND_EN defined:
  - Each node also tracks a runner-up: second = better(loser.best, winner.second), using the same node rule.
  - The runner-up ports exist and are pipelined alongside the best result with the same latency.
  - vld_2nd=0 when fewer than two windows are valid.
- GEM_SORT_SECOND_EN undefined: the runner-up ports and logic are absent. The best-result behaviour is unchanged.

## Structure
- Shared package gem_sort_pkg holds:
  - the candidate struct/field-width constants: PRI_W_DEF=10, XKY_W_DEF=10;
  - NOMATCH_CNT_W=16;
  - the tie-break rule, documented as the constant TIE_LOW_IDX=1.
- Sub-module gem_sort_node: combinational compare-select of two candidates (best plus optional second). It is instantiated N_WIN-1 times by generate loops; the top module owns the registers.

## Test plan
- N_WIN=16, all valid, pri[i]=100-i, single valid_in -> after 4 cycles valid_out=1, win_best=15, pri_best=85, xky_best=gem_xky[15].
- All valid with pri[3]=pri[9]=7 and all others 20 -> win_best=3 (tie goes to lower index); with GEM_SORT_SECOND_EN, win_2nd=9.
- win_vld=0 for 3 consecutive events -> best_vld=0 and all result fields 0 each time; nomatch_cnt=3. Then pulse cnt_clr together with a fourth no-match event -> nomatch_cnt=0.
- Only window 12 valid, with pri[12]=1023 and all others pri 0 -> win_best=12, pri_best=1023; vld_2nd=0.
- Back-to-back events on 6 consecutive cycles with random data -> 6 consecutive valid_out cycles, each matching a reference model in order.
- Assert reset_n low 2 cycles after injecting 3 events -> no valid_out afterwards, all outputs 0, nomatch_cnt=0.
